// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the data-cache miss handler.
package dcache_pkg;

    localparam int unsigned WAYS_DEF       = 4;
    localparam int unsigned LINE_WORDS_DEF = 4;
    localparam int unsigned ADDR_W_DEF     = 20;
    localparam int unsigned IDX_W_DEF      = 4;

    localparam int unsigned AW    = $clog2(WAYS_DEF);
    localparam int unsigned OW    = $clog2(LINE_WORDS_DEF);
    localparam int unsigned TAG_W = ADDR_W_DEF - IDX_W_DEF - OW - 2;

    typedef enum logic [2:0] {
        StIdle,
        StVictim,
        StWb,
        StFill,
        StUpdate,
        StResp
    } miss_state_e;

    function automatic int unsigned tag_width(int unsigned addr_w, int unsigned idx_w,
                                              int unsigned line_words);
        return addr_w - idx_w - $clog2(line_words) - 2;
    endfunction

endpackage

// File: rtl/dcache_lru_sel.sv
// Victim pick (first invalid way, else oldest, else way 0) and LRU age update.
module dcache_lru_sel import dcache_pkg::*; #(
    parameter int unsigned WAYS  = WAYS_DEF,
    parameter int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]       way_valid_i,
    input  logic [WAYS*WAY_W-1:0] way_age_i,
    output logic [WAY_W-1:0]      victim_o,
    output logic [WAYS*WAY_W-1:0] age_next_o
);

    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] old_way;
    logic [WAY_W-1:0] old_age;
    logic [WAY_W-1:0] age_cur;

    always_comb begin
        inv_found  = 1'b0;
        inv_way    = '0;
        old_way    = '0;
        age_cur    = '0;
        age_next_o = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!way_valid_i[i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
            if (way_age_i[i*WAY_W +: WAY_W] == WAY_W'(WAYS - 1)) begin
                old_way = WAY_W'(i);
            end
        end
        victim_o = inv_found ? inv_way : old_way;
        old_age  = inv_found ? WAY_W'(WAYS - 1) : way_age_i[victim_o*WAY_W +: WAY_W];
        for (int i = 0; i < WAYS; i++) begin
            age_cur = way_age_i[i*WAY_W +: WAY_W];
            if (WAY_W'(i) == victim_o) begin
                age_next_o[i*WAY_W +: WAY_W] = '0;
            end else if (age_cur < old_age) begin
                age_next_o[i*WAY_W +: WAY_W] = age_cur + WAY_W'(1);
            end else begin
                age_next_o[i*WAY_W +: WAY_W] = age_cur;
            end
        end
    end

endmodule

// File: rtl/dcache_miss_fsm.sv
// Data-cache miss handler: victim select, dirty write-back, line fill, array update, response.
module dcache_miss_fsm import dcache_pkg::*; #(
    parameter  int unsigned WAYS       = WAYS_DEF,
    parameter  int unsigned LINE_WORDS = LINE_WORDS_DEF,
    parameter  int unsigned ADDR_W     = ADDR_W_DEF,
    parameter  int unsigned IDX_W      = IDX_W_DEF,
    localparam int unsigned WAY_W      = $clog2(WAYS),
    localparam int unsigned OFF_W      = $clog2(LINE_WORDS),
    localparam int unsigned TAG_BITS   = tag_width(ADDR_W, IDX_W, LINE_WORDS)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       miss_req_i,
    input  logic [ADDR_W-1:0]          miss_addr_i,
    input  logic                       miss_write_i,
    input  logic [31:0]                miss_wdata_i,
    output logic                       miss_busy_o,
    output logic                       miss_ack_o,
    output logic [31:0]                miss_rdata_o,
    output logic [WAY_W-1:0]           victim_way_o,
    input  logic [WAYS-1:0]            way_valid_i,
    input  logic [WAYS-1:0]            way_dirty_i,
    input  logic [WAYS*WAY_W-1:0]      way_age_i,
    input  logic [TAG_BITS-1:0]        victim_tag_i,
    input  logic [LINE_WORDS*32-1:0]   victim_data_i,
    output logic                       mem_req_o,
    output logic                       mem_wr_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [31:0]                mem_wdata_o,
    input  logic                       mem_ready_i,
    input  logic                       mem_rvalid_i,
    input  logic [31:0]                mem_rdata_i,
    output logic                       fill_we_o,
    output logic [WAY_W-1:0]           fill_way_o,
    output logic [LINE_WORDS*32-1:0]   fill_data_o,
    output logic [TAG_BITS+1:0]        tag_wdata_o,
    output logic [WAYS*WAY_W-1:0]      age_wdata_o
);

    localparam int unsigned IDX_LSB = OFF_W + 2;
    localparam int unsigned TAG_LSB = IDX_W + OFF_W + 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    miss_state_e              state_q;
    logic [ADDR_W-3:0]        addr_q;
    logic                     write_q;
    logic [31:0]              wdata_q;
    logic [WAY_W-1:0]         way_q;
    logic [WAYS*WAY_W-1:0]    age_q;
    logic [TAG_BITS-1:0]      vtag_q;
    logic [LINE_WORDS*32-1:0] line_q;
    logic [OFF_W:0]           beat_q;  // MSB set once every fill beat has issued
    logic [OFF_W-1:0]         rcv_q;

    logic [WAY_W-1:0]         lru_victim;
    logic [WAYS*WAY_W-1:0]    lru_age;
    logic [OFF_W-1:0]         off;
    logic [IDX_W-1:0]         idx;
    logic [TAG_BITS-1:0]      tag;
    logic                     fill_issue;
    logic                     in_update;
    logic                     unused_addr_lsb;

    assign unused_addr_lsb = ^miss_addr_i[1:0];
    assign off = addr_q[IDX_LSB-3:0];
    assign idx = addr_q[TAG_LSB-3:IDX_LSB-2];
    assign tag = addr_q[ADDR_W-3:TAG_LSB-2];

    dcache_lru_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_lru_sel (
        .way_valid_i (way_valid_i),
        .way_age_i   (way_age_i),
        .victim_o    (lru_victim),
        .age_next_o  (lru_age)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            way_q   <= '0;
            age_q   <= '0;
            vtag_q  <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            rcv_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (miss_req_i) begin
                        addr_q  <= miss_addr_i[ADDR_W-1:2];
                        write_q <= miss_write_i;
                        wdata_q <= miss_wdata_i;
                        way_q   <= lru_victim;
                        age_q   <= lru_age;
                        state_q <= StVictim;
                    end
                end
                StVictim: begin
                    line_q  <= victim_data_i;
                    vtag_q  <= victim_tag_i;
                    state_q <= (way_valid_i[way_q] && way_dirty_i[way_q]) ? StWb : StFill;
                end
                StWb: begin
                    if (mem_ready_i) begin
                        if (beat_q[OFF_W-1:0] == LAST_BEAT) begin
                            beat_q  <= '0;
                            state_q <= StFill;
                        end else begin
                            beat_q <= beat_q + (OFF_W+1)'(1);
                        end
                    end
                end
                StFill: begin
                    if (fill_issue && mem_ready_i) begin
                        beat_q <= beat_q + (OFF_W+1)'(1);
                    end
                    // Store data overrides the returning word at the miss offset.
                    if (mem_rvalid_i) begin
                        line_q[rcv_q*32 +: 32] <= (write_q && rcv_q == off) ? wdata_q : mem_rdata_i;
                        if (rcv_q == LAST_BEAT) begin
                            rcv_q   <= '0;
                            beat_q  <= '0;
                            state_q <= StUpdate;
                        end else begin
                            rcv_q <= rcv_q + OFF_W'(1);
                        end
                    end
                end
                StUpdate: state_q <= StResp;
                StResp:   state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign fill_issue = (state_q == StFill) && !beat_q[OFF_W];
    assign in_update  = (state_q == StUpdate);

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == StWb) begin
            mem_addr_o  = {vtag_q, idx, beat_q[OFF_W-1:0], 2'b00};
            mem_wdata_o = line_q[beat_q[OFF_W-1:0]*32 +: 32];
        end else if (fill_issue) begin
            mem_addr_o = {tag, idx, beat_q[OFF_W-1:0], 2'b00};
        end
    end

    assign miss_busy_o  = (state_q != StIdle);
    assign miss_ack_o   = (state_q == StResp);
    assign miss_rdata_o = (miss_ack_o && !write_q) ? line_q[off*32 +: 32] : '0;
    assign victim_way_o = way_q;
    assign mem_req_o    = (state_q == StWb) || fill_issue;
    assign mem_wr_o     = (state_q == StWb);
    assign fill_we_o    = in_update;
    assign fill_way_o   = in_update ? way_q : '0;
    assign fill_data_o  = in_update ? line_q : '0;
    assign tag_wdata_o  = in_update ? {tag, 1'b1, write_q} : '0;
    assign age_wdata_o  = in_update ? age_q : '0;

endmodule

// File: tb/tb_dcache_miss_fsm.sv
// Directed and randomized miss scenarios checked against a line-level reference model.
module tb_dcache_miss_fsm;

    localparam int WAYS   = 4;
    localparam int LW     = 4;
    localparam int ADDR_W = 20;
    localparam int AW     = 2;
    localparam int TAG_W  = 12;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 miss_req;
    logic [ADDR_W-1:0]    miss_addr;
    logic                 miss_write;
    logic [31:0]          miss_wdata;
    logic                 miss_busy;
    logic                 miss_ack;
    logic [31:0]          miss_rdata;
    logic [AW-1:0]        victim_way;
    logic [WAYS-1:0]      way_valid;
    logic [WAYS-1:0]      way_dirty;
    logic [WAYS*AW-1:0]   way_age;
    logic [TAG_W-1:0]     victim_tag;
    logic [LW*32-1:0]     victim_data;
    logic                 mem_req;
    logic                 mem_wr;
    logic [ADDR_W-1:0]    mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_ready;
    logic                 mem_rvalid;
    logic [31:0]          mem_rdata;
    logic                 fill_we;
    logic [AW-1:0]        fill_way;
    logic [LW*32-1:0]     fill_data;
    logic [TAG_W+1:0]     tag_wdata;
    logic [WAYS*AW-1:0]   age_wdata;

    int checks = 0;
    int failures = 0;

    logic [TAG_W-1:0] way_tag [WAYS];
    logic [31:0]      way_line [WAYS][LW];

    always #5 clk = ~clk;

    dcache_miss_fsm u_dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .miss_req_i    (miss_req),
        .miss_addr_i   (miss_addr),
        .miss_write_i  (miss_write),
        .miss_wdata_i  (miss_wdata),
        .miss_busy_o   (miss_busy),
        .miss_ack_o    (miss_ack),
        .miss_rdata_o  (miss_rdata),
        .victim_way_o  (victim_way),
        .way_valid_i   (way_valid),
        .way_dirty_i   (way_dirty),
        .way_age_i     (way_age),
        .victim_tag_i  (victim_tag),
        .victim_data_i (victim_data),
        .mem_req_o     (mem_req),
        .mem_wr_o      (mem_wr),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_ready_i   (mem_ready),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata),
        .fill_we_o     (fill_we),
        .fill_way_o    (fill_way),
        .fill_data_o   (fill_data),
        .tag_wdata_o   (tag_wdata),
        .age_wdata_o   (age_wdata)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [ADDR_W-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {miss_busy, miss_ack, victim_way, mem_req, mem_wr, fill_we, fill_way,
                            tag_wdata, age_wdata}, '0);
        chk({tag, "_data"}, {miss_rdata, mem_addr, mem_wdata}, '0);
        chk({tag, "_fill"}, fill_data, '0);
    endtask

    task automatic randomize_ways();
        for (int w = 0; w < WAYS; w++) begin
            way_tag[w] = TAG_W'($urandom);
            for (int b = 0; b < LW; b++) way_line[w][b] = $urandom;
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1 on write beats.
    task automatic run_miss(input logic [ADDR_W-1:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] valid, input logic [3:0] dirty,
                            input logic [7:0] ages, input int ready_mode, input int abort_beat,
                            input bit pulse_req, input bit check_lat);
        int v;
        int old_age;
        int a;
        logic [7:0]        exp_ages;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] wb_base;
        logic [127:0]      exp_line;
        logic [31:0]       exp_rdata;
        bit                do_wb;
        int cycles, busy_cyc, nwr, nrd_iss, nrd_done, nfill, nack, post, pat_i;
        bit                hold_v;
        logic [ADDR_W-1:0] hold_a;
        logic [31:0]       pend[$];
        bit                pat [4];

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        // Reference: victim, ages, expected write-back and fill contents.
        v = -1;
        for (int i = 0; i < WAYS; i++) if (!valid[i] && v < 0) v = i;
        if (v < 0) begin
            v = 0;
            for (int i = 0; i < WAYS; i++) if (ages[i*AW +: AW] == WAYS - 1) begin v = i; break; end
        end
        old_age = valid[v] ? int'(ages[v*AW +: AW]) : WAYS - 1;
        for (int i = 0; i < WAYS; i++) begin
            a = int'(ages[i*AW +: AW]);
            if (i == v) a = 0;
            else if (a < old_age) a = a + 1;
            exp_ages[i*AW +: AW] = AW'(a);
        end
        do_wb   = valid[v] && dirty[v];
        base    = {addr[19:4], 4'h0};
        wb_base = {way_tag[v], addr[7:4], 4'h0};
        for (int b = 0; b < LW; b++) begin
            exp_line[b*32 +: 32] = (wr && b == int'(addr[3:2])) ? wd : memfn(base + 20'(4*b));
        end
        exp_rdata = wr ? 32'h0 : memfn(base + 20'(4*int'(addr[3:2])));

        miss_addr = addr; miss_write = wr; miss_wdata = wd;
        way_valid = valid; way_dirty = dirty; way_age = ages;
        miss_req = 1'b1; mem_ready = 1'b1; mem_rvalid = 1'b0;
        cycles = 0; busy_cyc = 0; nwr = 0; nrd_iss = 0; nrd_done = 0;
        nfill = 0; nack = 0; post = 0; pat_i = 0; hold_v = 1'b0; hold_a = '0;

        while (post < 3 && cycles < 300) begin
            @(posedge clk); #1;
            cycles++;
            victim_tag = way_tag[victim_way];
            for (int b = 0; b < LW; b++) victim_data[b*32 +: 32] = way_line[victim_way][b];
            if (miss_busy) busy_cyc++;
            if (hold_v) begin
                chk("held_req", mem_req, 1);
                chk("held_addr", mem_addr, hold_a);
                hold_v = 1'b0;
            end
            if (abort_beat > 0 && mem_req && !mem_wr && nrd_iss == abort_beat - 1) begin
                reset = 1'b1;
                #1;
                check_all_zero("abort_now");
                @(posedge clk); #1;
                check_all_zero("abort_next");
                miss_req = 1'b0; mem_rvalid = 1'b0;
                reset = 1'b0;
                return;
            end
            case (ready_mode)
                0: mem_ready = 1'b1;
                1: mem_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (mem_req && mem_wr) begin
                        mem_ready = pat[pat_i % 4];
                        pat_i++;
                    end else begin
                        mem_ready = 1'b1;
                    end
                end
            endcase
            if (pend.size() > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend.pop_front();
                nrd_done++;
            end else if (((nrd_iss == 0 && !(mem_req && !mem_wr)) || nrd_done == LW)
                         && $urandom_range(0, 2) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
            end
            if (mem_req && mem_ready) begin
                if (mem_wr) begin
                    chk("wb_addr", mem_addr, wb_base + 20'(4*nwr));
                    chk("wb_data", mem_wdata, way_line[v][nwr % LW]);
                    nwr++;
                end else begin
                    if (nrd_iss == 0) chk("rd_after_wb", nwr, do_wb ? LW : 0);
                    chk("rd_addr", mem_addr, base + 20'(4*nrd_iss));
                    pend.push_back(memfn(mem_addr));
                    nrd_iss++;
                end
            end else if (mem_req) begin
                hold_v = 1'b1;
                hold_a = mem_addr;
            end
            if (fill_we) begin
                nfill++;
                chk("fill_way", fill_way, v);
                chk("fill_data", fill_data, exp_line);
                chk("tag_wdata", tag_wdata, {addr[19:8], 1'b1, wr});
                chk("age_wdata", age_wdata, exp_ages);
            end
            if (miss_ack) begin
                nack++;
                chk("miss_rdata", miss_rdata, exp_rdata);
                miss_req = 1'b0;
            end
            if (pulse_req) begin
                if (cycles == 3) miss_req = 1'b0;
                else if (cycles == 5) miss_req = 1'b1;
                else if (cycles == 6) miss_req = 1'b0;
            end
            if (nack > 0) post++;
        end
        chk("no_timeout", cycles < 300, 1);
        chk("wb_beats", nwr, do_wb ? LW : 0);
        chk("rd_beats", nrd_iss, LW);
        chk("fill_we_count", nfill, 1);
        chk("ack_count", nack, 1);
        chk("idle_after", miss_busy, 0);
        if (check_lat) chk("latency", busy_cyc, 1 + LW + 1 + 2);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        int p [4];
        int j;
        int t;
        logic [7:0] ages;

        reset = 1'b1; miss_req = 1'b0; miss_addr = '0; miss_write = 1'b0; miss_wdata = '0;
        way_valid = '0; way_dirty = '0; way_age = '0; victim_tag = '0; victim_data = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        randomize_ways();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Load miss, clean full set, ages 3/1/0/2.
        run_miss(20'h01234, 1'b0, 32'h0, 4'b1111, 4'b0000, {2'd2, 2'd0, 2'd1, 2'd3}, 0, 0, 0, 1);

        // Store miss, way2 oldest and dirty with tag 0x0AB.
        randomize_ways();
        way_tag[2] = 12'h0AB;
        run_miss(20'h0567C, 1'b1, 32'hDEADBEEF, 4'b1111, 4'b0100, {2'd2, 2'd3, 2'd1, 2'd0},
                 0, 0, 0, 0);

        // Invalid way wins over age.
        randomize_ways();
        run_miss(20'h3A5C8, 1'b0, 32'h0, 4'b1011, 4'b1111, {2'd3, 2'd0, 2'd1, 2'd2}, 1, 0, 0, 0);

        // Write-back with stalled beats.
        randomize_ways();
        run_miss(20'h7F0E4, 1'b0, 32'h0, 4'b1111, 4'b0001, {2'd1, 2'd2, 2'd0, 2'd3}, 2, 0, 0, 0);

        // Reset during the 2nd fill beat, then a normal miss.
        randomize_ways();
        run_miss(20'h12348, 1'b1, 32'hCAFE0001, 4'b1111, 4'b0000, {2'd0, 2'd1, 2'd2, 2'd3},
                 0, 2, 0, 0);
        run_miss(20'h12348, 1'b1, 32'hCAFE0001, 4'b1111, 4'b0000, {2'd0, 2'd1, 2'd2, 2'd3},
                 0, 0, 0, 0);

        // Request pulsed while busy.
        randomize_ways();
        run_miss(20'h0BEEC, 1'b0, 32'h0, 4'b1111, 4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 1, 0, 1, 0);

        // Randomized misses over permuted ages.
        for (int n = 0; n < 20; n++) begin
            randomize_ways();
            p = '{0, 1, 2, 3};
            for (int i = WAYS - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = p[i]; p[i] = p[j]; p[j] = t;
            end
            for (int i = 0; i < WAYS; i++) ages[i*AW +: AW] = AW'(p[i]);
            run_miss(20'($urandom), 1'($urandom), $urandom,
                     ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF, 4'($urandom), ages,
                     1, 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_miss_fsm.md
DCACHE_MISS_FSM -- requirements
Module: dcache_miss_fsm

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity, power of 2, range 2..8; AW = log2(WAYS).
REQ-002 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line, power of 2, range 2..8; OW = log2(LINE_WORDS).
REQ-003 SHALL have parameter ADDR_W, default 20, and parameter IDX_W, default 4; TAG_W = ADDR_W-IDX_W-OW-2.
REQ-004 SHALL provide the following ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- miss_req  in  1  miss request; sampled only in IDLE.
- miss_addr  in  ADDR_W  byte address of the miss.
- miss_write  in  1  miss is a store.
- miss_wdata  in  32  store data.
- miss_busy  out  1  high in any state other than IDLE.
- miss_ack  out  1  one-cycle completion pulse.
- miss_rdata  out  32  requested word, valid with miss_ack on loads; 0 otherwise.
- victim_way  out  AW  way whose tag and data the arrays return.
- way_valid / way_dirty  in  WAYS  per-way state for the indexed set.
- way_age  in  WAYS*AW  per-way LRU age; 0 = newest.
- victim_tag  in  TAG_W  tag of victim_way.
- victim_data  in  LINE_WORDS*32  line of victim_way.
- mem_req / mem_wr  out  1  memory beat request; mem_wr=1 means write.
- mem_addr  out  ADDR_W  beat address.
- mem_wdata  out  32  write-beat data.
- mem_ready  in  1  current beat accepted.
- mem_rvalid / mem_rdata  in  1 / 32  read beat return.
- fill_we  out  1  one-cycle data, tag and age array write strobe.
- fill_way  out  AW  way to write.
- fill_data  out  LINE_WORDS*32  line to write.
- tag_wdata  out  TAG_W+2  {tag, valid, dirty}.
- age_wdata  out  WAYS*AW  updated ages.

Function
REQ-005 SHALL implement states IDLE, VICTIM, WB, FILL, UPDATE, RESP.
- IDLE: on miss_req, latch addr/write/wdata and compute victim -> VICTIM.
- VICTIM: one cycle for the arrays to present victim_tag/victim_data -> WB if the victim is valid and dirty, else FILL.
- WB: LINE_WORDS write beats, offsets 0..LINE_WORDS-1 -> FILL.
- FILL: LINE_WORDS read beats -> UPDATE.
- UPDATE: fill_we high for one cycle -> RESP.
- RESP: miss_ack high for one cycle -> IDLE.
REQ-006 Victim selection SHALL be: the lowest-index invalid way; else the way with age == WAYS-1; if no way has that age, way 0.
REQ-007 WB SHALL latch victim_data on VICTIM exit; write addresses SHALL be {victim_tag, index, beat, 2'b00}; the beat counter SHALL advance only when mem_req && mem_ready.
REQ-008 FILL SHALL hold mem_req=1 and mem_wr=0, with mem_addr = {miss tag, index, beat, 2'b00}.
- Each beat issues when mem_ready is high.
- mem_rvalid beats are stored in arrival order into word 0..LINE_WORDS-1.
- mem_rvalid outside FILL SHALL be ignored.
REQ-009 On a store miss, the word at the miss offset SHALL be replaced by miss_wdata before UPDATE, and tag_wdata SHALL be {tag,1,1}; on a load miss, tag_wdata SHALL be {tag,1,0}.
REQ-010 Age update in UPDATE:
- The victim way gets age 0.
- Every way whose age is below the victim's old age is incremented.
- All other ways are unchanged.
- An invalid victim's old age counts as WAYS-1.
REQ-011 miss_req while busy SHALL be ignored; the requester holds it until miss_ack.
REQ-012 mem_req SHALL be low in IDLE, VICTIM, UPDATE and RESP; beat counters SHALL wrap to 0 on every state exit.
REQ-013 Latency with a clean victim and mem_ready tied high SHALL be 1 (VICTIM) + LINE_WORDS (FILL, plus read latency) + 2 cycles.

Reset
REQ-014 Reset SHALL force IDLE and drive every output to 0, including mem_req, fill_we and miss_ack; reset mid-transfer SHALL abandon the transfer and issue no further beats.

Structure
REQ-015 A shared package dcache_pkg SHALL hold the state enum, default parameter values, and the field-width helper constants TAG_W, OW and AW.
REQ-016 Sub-module dcache_lru_sel (combinational victim pick plus age update) SHALL be instantiated once.

Verification
REQ-017 The bench SHALL cover these directed scenarios (defaults, ages 0..3):
- Load miss 0x01234, all ways valid and clean, ways=3/1/0/2 -> no write beats; 4 read beats from 0x01230; fill_way=0; ages 0/2/1/3; miss_ack with word 1.
- Store miss 0x0567C, wdata 0xDEADBEEF, way2 oldest and dirty, victim_tag=0x0AB -> 4 write beats from 0x0AB70, then 4 read beats; fill word 3 = 0xDEADBEEF; tag_wdata dirty=1.
- way_valid=4'b1011 -> fill_way=2 regardless of ages.
- mem_ready toggling 1,0,0,1 in WB -> each beat address is held until accepted; exactly 4 write beats.
- Reset asserted during the 2nd FILL beat -> all outputs 0 next cycle; a new miss then completes normally.
- miss_req pulsed while busy -> ignored; exactly one miss_ack.
